// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states and the
// per-stage enable/flush bundle with its three canonical settings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        ACC_WAIT    = 2'd1,
        ACC_RELEASE = 2'd2
    } pc_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pc_ctrl_t;

    // Free-running pipeline, squash of the two youngest stages, and front-end freeze with bubble into EX
    localparam pc_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam pc_ctrl_t CTRL_SQUASH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam pc_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect: a load in EX whose destination feeds the ID instruction.
module hazard_unit #(
    parameter int REGAW = 5
) (
    input  logic             ex_memread,
    input  logic [REGAW-1:0] ex_rd,
    input  logic [REGAW-1:0] id_rs1,
    input  logic [REGAW-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             lu
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rs1_hit_s = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit_s = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu        = ex_memread && (ex_rd != {REGAW{1'b0}}) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipelinereg.sv
// Generic pipeline stage register with enable and bubble-insert (clear) select.
module pipelinereg #(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush,
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] q
);

    logic [DWIDTH-1:0] q_r;

    // Stage register: flush loads zero, enable loads d, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= {DWIDTH{1'b0}};
        end else if (flush) begin
            q_r <= {DWIDTH{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use stalls, branch squash,
// and a start/done handshake that freezes the front end during accelerator ops.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DWIDTH      = 64,
    parameter int REGAW       = 5,
    parameter int ACC_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REGAW-1:0]  id_rs1,
    input  logic [REGAW-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_acc_op,
    input  logic [REGAW-1:0]  ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              acc_done,
    input  logic [DWIDTH-1:0] acc_result,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              acc_start,
    output logic [DWIDTH-1:0] acc_data,
    output logic              acc_err
);

    localparam int              CNTW     = $clog2(ACC_TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ACC_TIMEOUT - 1);

    pc_state_t         state_r;
    pc_state_t         state_nxt_s;
    logic [CNTW-1:0]   cnt_r;
    logic [CNTW-1:0]   cnt_nxt_s;
    logic              acc_start_r;
    logic              acc_err_r;
    logic              issue_s;
    logic              lu_s;
    logic              accept_s;
    logic              timeout_s;
    logic              latch_en_s;
    logic [DWIDTH-1:0] latch_d_s;
    pc_ctrl_t          ctrl_s;

    hazard_unit #(
        .REGAW (REGAW)
    ) u_hazard (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .lu         (lu_s)
    );

    // A done coinciding with the start pulse is stale; done beats timeout in the same cycle
    assign accept_s   = (state_r == ACC_WAIT) && !acc_start_r && acc_done;
    assign timeout_s  = (state_r == ACC_WAIT) && !accept_s && (cnt_r == CNT_LAST);
    assign latch_en_s = accept_s || timeout_s;
    assign latch_d_s  = timeout_s ? {DWIDTH{1'b0}} : acc_result;

    // Next-state, counter and stage-control decode
    always_comb begin
        ctrl_s      = CTRL_RUN;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        issue_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (ex_branch_taken) begin
                    ctrl_s = CTRL_SQUASH;
                end else if (lu_s) begin
                    ctrl_s = CTRL_STALL;
                end else if (id_acc_op) begin
                    ctrl_s      = CTRL_STALL;
                    state_nxt_s = ACC_WAIT;
                    cnt_nxt_s   = {CNTW{1'b0}};
                    issue_s     = 1'b1;
                end else begin
                    ctrl_s = CTRL_RUN;
                end
            end
            ACC_WAIT: begin
                ctrl_s = CTRL_STALL;
                if (latch_en_s) begin
                    state_nxt_s = ACC_RELEASE;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            ACC_RELEASE: begin
                ctrl_s      = CTRL_RUN;
                state_nxt_s = RUN;
            end
            default: begin
                ctrl_s      = CTRL_RUN;
                state_nxt_s = RUN;
            end
        endcase
    end

    // State, wait counter, start pulse and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= RUN;
            cnt_r       <= {CNTW{1'b0}};
            acc_start_r <= 1'b0;
            acc_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            acc_start_r <= issue_s;
            acc_err_r   <= acc_err_r || timeout_s;
        end
    end

    pipelinereg #(
        .DWIDTH (DWIDTH)
    ) u_acc_data (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (latch_en_s),
        .flush   (1'b0),
        .d       (latch_d_s),
        .q       (acc_data)
    );

    assign pc_en      = ctrl_s.pc_en;
    assign ifid_en    = ctrl_s.ifid_en;
    assign idex_en    = ctrl_s.idex_en;
    assign exmem_en   = ctrl_s.exmem_en;
    assign memwb_en   = ctrl_s.memwb_en;
    assign ifid_flush = ctrl_s.ifid_flush;
    assign idex_flush = ctrl_s.idex_flush;
    assign acc_start  = acc_start_r;
    assign acc_err    = acc_err_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with a short accelerator timeout.
module tb_pipeline_ctrl;

    localparam int DWIDTH = 64;
    localparam int REGAW  = 5;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] V_RUN    = 7'b1111100;
    localparam logic [6:0] V_STALL  = 7'b0011101;
    localparam logic [6:0] V_SQUASH = 7'b1111111;

    logic              clk;
    logic              reset_n;
    logic [REGAW-1:0]  id_rs1;
    logic [REGAW-1:0]  id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_acc_op;
    logic [REGAW-1:0]  ex_rd;
    logic              ex_memread;
    logic              ex_branch_taken;
    logic              acc_done;
    logic [DWIDTH-1:0] acc_result;
    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              acc_start;
    logic [DWIDTH-1:0] acc_data;
    logic              acc_err;
    logic [6:0]        ctrl_v;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(
        .DWIDTH      (DWIDTH),
        .REGAW       (REGAW),
        .ACC_TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_acc_op       (id_acc_op),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .acc_done        (acc_done),
        .acc_result      (acc_result),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .acc_start       (acc_start),
        .acc_data        (acc_data),
        .acc_err         (acc_err)
    );

    assign ctrl_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_acc_op = 1'b0; ex_rd = 5'd0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
        acc_done = 1'b0; acc_result = 64'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #12;
        checks++;
        if (acc_start !== 1'b0) begin errors++; $display("FAIL reset_acc_start: got %b want 0", acc_start); end
        checks++;
        if (acc_data !== 64'd0) begin errors++; $display("FAIL reset_acc_data: got %h want 0", acc_data); end
        checks++;
        if (acc_err !== 1'b0) begin errors++; $display("FAIL reset_acc_err: got %b want 0", acc_err); end
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl_v, V_RUN); end
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_use();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctrl_v !== V_STALL) begin errors++; $display("FAIL lu_rs2_stall: got %b want %b", ctrl_v, V_STALL); end
        next_cycle();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1;
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL lu_release: got %b want %b", ctrl_v, V_RUN); end
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd1;
        #1;
        checks++;
        if (ctrl_v !== V_STALL) begin errors++; $display("FAIL lu_rs1_stall: got %b want %b", ctrl_v, V_STALL); end
        id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL lu_rs1_unused: got %b want %b", ctrl_v, V_RUN); end
        next_cycle();
    endtask

    task automatic test_x0();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL x0_no_stall: got %b want %b", ctrl_v, V_RUN); end
        next_cycle();
    endtask

    task automatic test_branch_priority();
        idle();
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_acc_op = 1'b1;
        #1;
        checks++;
        if (ctrl_v !== V_SQUASH) begin errors++; $display("FAIL branch_squash: got %b want %b", ctrl_v, V_SQUASH); end
        next_cycle();
        idle();
        #1;
        checks++;
        if (acc_start !== 1'b0) begin errors++; $display("FAIL branch_no_start: got %b want 0", acc_start); end
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL branch_stays_run: got %b want %b", ctrl_v, V_RUN); end
        next_cycle();
    endtask

    task automatic test_acc_latency();
        idle();
        id_acc_op = 1'b1;
        #1;
        checks++;
        if (ctrl_v !== V_STALL || acc_start !== 1'b0) begin
            errors++; $display("FAIL acc_c0: got ctrl %b start %b want %b 0", ctrl_v, acc_start, V_STALL);
        end
        next_cycle();
        acc_done = 1'b1; acc_result = 64'h1111;
        #1;
        checks++;
        if (acc_start !== 1'b1 || ctrl_v !== V_STALL) begin
            errors++; $display("FAIL acc_c1_start: got start %b ctrl %b want 1 %b", acc_start, ctrl_v, V_STALL);
        end
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            acc_done = (c == 5) ? 1'b1 : 1'b0;
            acc_result = (c == 5) ? 64'hDEAD_BEEF : 64'd0;
            #1;
            checks++;
            if (ctrl_v !== V_STALL || acc_start !== 1'b0) begin
                errors++; $display("FAIL acc_wait_c%0d: got ctrl %b start %b want %b 0", c, ctrl_v, acc_start, V_STALL);
            end
        end
        next_cycle();
        acc_done = 1'b0; acc_result = 64'd0;
        #1;
        checks++;
        if (ctrl_v !== V_RUN || acc_data !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL acc_release: got ctrl %b data %h want %b deadbeef", ctrl_v, acc_data, V_RUN);
        end
        next_cycle();
        id_acc_op = 1'b0; acc_done = 1'b1; acc_result = 64'h5;
        #1;
        checks++;
        if (ctrl_v !== V_RUN || acc_err !== 1'b0) begin
            errors++; $display("FAIL acc_back_run: got ctrl %b err %b want %b 0", ctrl_v, acc_err, V_RUN);
        end
        next_cycle();
        acc_done = 1'b0;
        #1;
        checks++;
        if (acc_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL done_ignored_run: got %h want deadbeef", acc_data); end
        next_cycle();
    endtask

    task automatic test_done_at_timeout();
        idle();
        id_acc_op = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            acc_done = (c == 8) ? 1'b1 : 1'b0;
            acc_result = (c == 8) ? 64'h77 : 64'd0;
        end
        next_cycle();
        acc_done = 1'b0; acc_result = 64'd0;
        #1;
        checks++;
        if (acc_data !== 64'h77 || acc_err !== 1'b0 || ctrl_v !== V_RUN) begin
            errors++; $display("FAIL done_wins: got data %h err %b ctrl %b want 77 0 %b", acc_data, acc_err, ctrl_v, V_RUN);
        end
        next_cycle();
        id_acc_op = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout();
        idle();
        id_acc_op = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            checks++;
            if (ctrl_v !== V_STALL || acc_err !== 1'b0) begin
                errors++; $display("FAIL to_wait_c%0d: got ctrl %b err %b want %b 0", c, ctrl_v, acc_err, V_STALL);
            end
        end
        next_cycle();
        checks++;
        if (acc_err !== 1'b1 || acc_data !== 64'd0 || ctrl_v !== V_RUN) begin
            errors++; $display("FAIL timeout: got err %b data %h ctrl %b want 1 0 %b", acc_err, acc_data, ctrl_v, V_RUN);
        end
        next_cycle();
        id_acc_op = 1'b0;
        next_cycle();
        id_acc_op = 1'b1;
        next_cycle();
        next_cycle();
        acc_done = 1'b1; acc_result = 64'hABC;
        next_cycle();
        idle();
        #1;
        checks++;
        if (acc_err !== 1'b1 || acc_data !== 64'hABC) begin
            errors++; $display("FAIL err_sticky: got err %b data %h want 1 abc", acc_err, acc_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        idle();
        id_acc_op = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
        end
        id_acc_op = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (acc_start !== 1'b0 || acc_data !== 64'd0 || acc_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wait_regs: got start %b data %h err %b want 0 0 0", acc_start, acc_data, acc_err);
        end
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL rst_mid_wait_state: got %b want %b", ctrl_v, V_RUN); end
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (ctrl_v !== V_RUN) begin errors++; $display("FAIL post_reset_run: got %b want %b", ctrl_v, V_RUN); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_branch_priority();
        test_acc_latency();
        test_done_at_timeout();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage RISC-V core, the control-side counterpart of the `pipelinereg` stage registers. It drives the per-stage `en` inputs and bubble-insert (flush) selects, detects load-use hazards and squashes on taken branches. It also runs a start/done handshake with the hardware accelerator, freezing the front end while an accelerator op in ID executes.

## Interface
- `DWIDTH`, 64: accelerator result width.
- `REGAW`, 5: register-index width.
- `ACC_TIMEOUT`, 256: maximum number of `ACC_WAIT` cycles before abort; must be ≥2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in REGAW: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction reads rs1 / rs2.
- `id_acc_op` in 1: the ID instruction is an accelerator op.
- `ex_rd` in REGAW: destination register of the instruction in EX.
- `ex_memread` in 1: the EX instruction is a load.
- `ex_branch_taken` in 1: the EX instruction redirects the PC.
- `acc_done` in 1: accelerator result valid, single-cycle pulse.
- `acc_result` in DWIDTH: accelerator result, valid with `acc_done`.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: stage-register enables.
- `ifid_flush`, `idex_flush` out 1: upstream mux selects NOP into IF/ID / ID/EX.
- `acc_start` out 1: registered one-cycle start pulse to the accelerator.
- `acc_data` out DWIDTH: latched accelerator result, forwarded into EX.
- `acc_err` out 1: sticky timeout flag.

## Operation
- FSM states (shared enum): `RUN`, `ACC_WAIT`, `ACC_RELEASE`. Reset state is `RUN`.
- Load-use hazard `lu` = `ex_memread` && `ex_rd`≠0 && ((`id_use_rs1` && `id_rs1`==`ex_rd`) || (`id_use_rs2` && `id_rs2`==`ex_rd`)).
- `RUN` follows a strict priority order:
  1. `ex_branch_taken`: all enables 1, `ifid_flush`=`idex_flush`=1. Stay in `RUN`. Overrides `lu` and `id_acc_op`.
  2. `lu`: `pc_en`=`ifid_en`=0, `idex_en`=1, `idex_flush`=1, `exmem_en`=`memwb_en`=1. Stay in `RUN`. The hazard clears on the following cycle once the load has moved to MEM.
  3. `id_acc_op`: same outputs as the `lu` case. Next state is `ACC_WAIT`; set `acc_start`; clear the counter.
  4. Otherwise all enables 1 and both flushes 0.
- `ACC_WAIT`:
  - `pc_en`=`ifid_en`=0, `idex_en`=1, `idex_flush`=1 (bubbles), `exmem_en`=`memwb_en`=1, so older instructions drain.
  - The IF/ID register holds the accelerator op, which keeps its operands stable.
  - `acc_done` is sampled only when `acc_start`=0. On an accepted done, latch `acc_result` into `acc_data` and go to `ACC_RELEASE`.
  - Otherwise the counter increments. When the counter reaches `ACC_TIMEOUT`-1 without done: set `acc_err`, set `acc_data`=0, go to `ACC_RELEASE`. If done and the timeout occur in the same cycle, done wins.
- `ACC_RELEASE`: all enables 1, flushes 0, the accelerator op advances to EX carrying `acc_data`. The `id_acc_op` issue check is suppressed this cycle. Next state is `RUN`.
- `acc_done` is ignored in `RUN` and `ACC_RELEASE`.
- `acc_err` clears only on reset.

## Timing
- Enables and flushes are combinational from state, the counter and the ID/EX inputs. There are no registered-output delays.
- `acc_start` is high exactly during the first `ACC_WAIT` cycle.
- Minimum accelerator latency is 1 cycle after `acc_start`.
- With done arriving N cycles after the issue cycle (N≥2), the front end stalls for N+1 cycles including the issue cycle. The op enters EX on the edge that ends `ACC_RELEASE`.
- Counter width is $clog2(`ACC_TIMEOUT`).
- Reset values: state `RUN`, counter 0, `acc_start` 0, `acc_data` 0, `acc_err` 0.
- Asserting `reset_n` mid-`ACC_WAIT` aborts immediately. The accelerator is expected to be reset by the same `reset_n`.

## Structure
- `pipe_ctrl_pkg`: state enum `pc_state_t` and the flush/enable bundle typedef.
- Sub-module `hazard_unit`: the combinational `lu` compare, reused later for forwarding.
- The `acc_data` latch is an instance of `pipelinereg`:
  - `DWIDTH`=`DWIDTH`;
  - `en` = accept or timeout;
  - data input muxed to 0 on timeout.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → exactly one cycle with `pc_en`=`ifid_en`=0, `idex_flush`=1; the next cycle is all-enable.
- Index x0: same stimulus as the load-use case but `ex_rd`=0 → no stall.
- Branch and hazard together: `ex_branch_taken`=1 together with `lu`=1 and `id_acc_op`=1 → both flushes 1, all enables 1, no `acc_start`, state stays `RUN`.
- Accelerator latency: `id_acc_op` at cycle 0 → `acc_start` at cycle 1; `acc_done` at cycle 5 with `acc_result`=0xDEAD_BEEF → `ACC_RELEASE` at cycle 6 with `acc_data`=0xDEADBEEF; `pc_en` low for cycles 0–5.
- Timeout: `ACC_TIMEOUT`=8, no done → `acc_err`=1 and `acc_data`=0 after 8 `ACC_WAIT` cycles; `acc_err` stays set through later ops until reset.
- Reset mid-`ACC_WAIT`: drop `reset_n` at counter=3 → state `RUN`, `acc_start`=0, `acc_data`=0 immediately (asynchronous).
